// File: rtl/mem_line_pkg.sv
// rtl/mem_line_pkg.sv - shared types and sizes for the line-transfer controller
package mem_line_pkg;

  localparam int NUM_BANKS  = 4;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS  = 128;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_t;

  // Word k of a line; word 0 sits in the low 32 bits.
  function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                            input logic [1:0] k);
    return line[32*k +: 32];
  endfunction

endpackage

// File: rtl/bank_rd_tracker.sv
// rtl/bank_rd_tracker.sv - RD_LAT-deep valid/index delay line for issued bank reads
module bank_rd_tracker #(
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [1:0] issue_idx,
  output logic       cap_valid,
  output logic [1:0] cap_idx
);

  logic [RD_LAT-1:0] vld_q;
  logic [1:0]        idx_q [RD_LAT];

  // Shift each issued read down the line so it emerges as the bank's data becomes valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) idx_q[i] <= 2'd0;
    end else begin
      vld_q[0] <= issue_valid;
      idx_q[0] <= issue_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign cap_valid = vld_q[RD_LAT-1];
  assign cap_idx   = idx_q[RD_LAT-1];

endmodule

// File: rtl/mem_line_ctrl.sv
// rtl/mem_line_ctrl.sv - splits 4-word line reads/writes into one access per bank
module mem_line_ctrl
  import mem_line_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [31:0]          req_addr,
  input  logic [LINE_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [LINE_BITS-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic [NUM_BANKS-1:0] bank_rd,
  output logic [NUM_BANKS-1:0] bank_wr,
  output logic [31:0]          bank_addr,
  output logic [31:0]          bank_wdata,
  input  logic [31:0]          bank_rdata0,
  input  logic [31:0]          bank_rdata1,
  input  logic [31:0]          bank_rdata2,
  input  logic [31:0]          bank_rdata3,
  input  logic [NUM_BANKS-1:0] bank_err
);

  state_t               state_q, state_d;
  logic [1:0]           k_q;
  logic [7:0]           drain_q;
  logic                 wr_q;
  logic [31:0]          addr_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic [LINE_BITS-1:0] rdata_q;
  logic                 err_q;
  logic                 prev_v_q;
  logic [1:0]           prev_k_q;
  logic                 accept;
  logic                 cap_valid;
  logic [1:0]           cap_idx;
  logic [31:0]          cap_word;

  assign accept = (state_q == IDLE) && req_valid;

  bank_rd_tracker #(.RD_LAT(RD_LAT)) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .issue_valid ((state_q == ISSUE) && !wr_q),
    .issue_idx   (k_q),
    .cap_valid   (cap_valid),
    .cap_idx     (cap_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and bank strobes; everything bank-facing is zero outside ISSUE.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    bank_en    = '0;
    bank_rd    = '0;
    bank_wr    = '0;
    bank_addr  = 32'd0;
    bank_wdata = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ISSUE;
      end
      ISSUE: begin
        bank_en[k_q] = 1'b1;
        bank_addr    = addr_q >> 2;
        if (wr_q) begin
          bank_wr[k_q] = 1'b1;
          bank_wdata   = line_word(wdata_q, k_q);
        end else begin
          bank_rd[k_q] = 1'b1;
        end
        if (k_q == 2'd3) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_q == 8'(RD_LAT - 1)) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch plus the issue and drain counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      k_q     <= 2'd0;
      drain_q <= 8'd0;
    end else begin
      if (accept) begin
        wr_q    <= req_wr;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      k_q     <= (state_q == ISSUE) ? k_q + 2'd1 : 2'd0;
      drain_q <= (state_q == DRAIN) ? drain_q + 8'd1 : 8'd0;
    end
  end

  // Sticky error: a bank's err is honoured in its issue cycle and the one after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= 1'b0;
      prev_v_q <= 1'b0;
      prev_k_q <= 2'd0;
    end else begin
      prev_v_q <= (state_q == ISSUE);
      prev_k_q <= k_q;
      if (accept)
        err_q <= 1'b0;
      else if (((state_q == ISSUE) && bank_err[k_q]) || (prev_v_q && bank_err[prev_k_q]))
        err_q <= 1'b1;
    end
  end

  // Pick the bank whose read is emerging from the tracker.
  always_comb begin
    cap_word = bank_rdata0;
    case (cap_idx)
      2'd1:    cap_word = bank_rdata1;
      2'd2:    cap_word = bank_rdata2;
      2'd3:    cap_word = bank_rdata3;
      default: cap_word = bank_rdata0;
    endcase
  end

  // Read line register; holds until the next read overwrites a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rdata_q <= '0;
    else if (cap_valid) rdata_q[32*cap_idx +: 32] <= cap_word;
  end

  assign rsp_rdata = (rsp_valid && wr_q) ? '0 : rdata_q;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb/tb_mem_line_ctrl.sv - scoreboard bench for mem_line_ctrl with behavioural banks
module tb_mem_line_ctrl;

  localparam int RD_LAT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_wr = 1'b0;
  logic [31:0]  req_addr = 32'd0;
  logic [127:0] req_wdata = '0;
  logic         rsp_valid;
  logic [127:0] rsp_rdata;
  logic         rsp_err;
  logic [3:0]   bank_en, bank_rd, bank_wr;
  logic [31:0]  bank_addr, bank_wdata;
  logic [31:0]  brd [4];
  logic [3:0]   bank_err = 4'd0;

  mem_line_ctrl #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bank_en(bank_en), .bank_rd(bank_rd), .bank_wr(bank_wr),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_rdata0(brd[0]), .bank_rdata1(brd[1]), .bank_rdata2(brd[2]), .bank_rdata3(brd[3]),
    .bank_err(bank_err)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [127:0] rdata; logic err; } rsp_t;
  typedef struct packed { logic [3:0] en, rd, wr; logic [31:0] addr, wd; } iss_t;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_acc = -100;
  bit   mon_en = 1'b0;
  rsp_t sb[$];
  iss_t exp_iss[int];
  logic [3:0]   err_sched[int];
  logic [127:0] ref_mem[logic [31:0]];
  logic [31:0]  bank_mem[logic [33:0]];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] default_word(input logic [31:0] key, input logic [1:0] k);
    return {key[29:0], k} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [3:0] err_at(input int c);
    return err_sched.exists(c) ? err_sched[c] : 4'd0;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1 bank_err = err_at(cyc);
  end

  // Behavioural banks: write on issue, read data appears RD_LAT cycles after issue.
  logic [3:0]  s_en, s_rd, s_wr;
  logic [31:0] s_addr, s_wd;
  logic        p1v[4], p2v[4];
  logic [31:0] p1d[4], p2d[4];
  initial for (int k = 0; k < 4; k++) begin p1v[k] = 0; p2v[k] = 0; brd[k] = 32'd0; end

  always @(negedge clk) begin
    s_en = bank_en; s_rd = bank_rd; s_wr = bank_wr; s_addr = bank_addr; s_wd = bank_wdata;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      logic [33:0] key;
      key = {k[1:0], s_addr};
      p2v[k] = p1v[k];
      p2d[k] = p1d[k];
      if (s_en[k] && s_wr[k]) bank_mem[key] = s_wd;
      p1v[k] = s_en[k] && s_rd[k];
      p1d[k] = bank_mem.exists(key) ? bank_mem[key] : default_word(s_addr, k[1:0]);
    end
    #1;
    for (int k = 0; k < 4; k++) brd[k] = p2v[k] ? p2d[k] : $urandom;
  end

  // Reference model: an accepted line occupies cycles a+1..a+4 on the banks and answers at a+5+RD_LAT.
  function automatic void model_accept(input int a, input logic wr, input logic [31:0] addr,
                                       input logic [127:0] wd);
    logic [31:0]  key;
    logic [127:0] line;
    logic         err;
    rsp_t         e;
    iss_t         s;
    key = addr >> 2;
    err = 1'b0;
    line = '0;
    if (!wr) begin
      if (ref_mem.exists(key)) line = ref_mem[key];
      else for (int k = 0; k < 4; k++) line[32*k +: 32] = default_word(key, k[1:0]);
    end
    for (int k = 0; k < 4; k++) begin
      logic [3:0] e1, e2;
      s.en   = 4'd1 << k;
      s.rd   = wr ? 4'd0 : s.en;
      s.wr   = wr ? s.en : 4'd0;
      s.addr = key;
      s.wd   = wr ? wd[32*k +: 32] : 32'd0;
      exp_iss[a + 1 + k] = s;
      e1 = err_at(a + 1 + k);
      e2 = err_at(a + 2 + k);
      err = err | e1[k] | e2[k];
    end
    if (wr) ref_mem[key] = wd;
    e.cyc = a + 5 + RD_LAT;
    e.rdata = line;
    e.err = err;
    sb.push_back(e);
    last_acc = a;
  endfunction

  // Monitor: per-cycle handshake/strobe checks and scoreboard pop on responses.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      iss_t s;
      rsp_t e;
      s = exp_iss.exists(cyc) ? exp_iss[cyc] : '0;
      chk("req_ready", req_ready, !(cyc > last_acc && cyc < last_acc + 6 + RD_LAT));
      chk("strobes", {bank_en, bank_rd, bank_wr}, {s.en, s.rd, s.wr});
      chk("bank_addr", bank_addr, s.addr);
      chk("bank_wdata", bank_wdata, s.wd);
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, 1'b1);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
      end else begin
        chk("rsp_valid_idle", rsp_valid, 1'b0);
      end
    end
  end

  // Present a request and hold it until the model says it is accepted.
  task automatic send(input logic wr, input logic [31:0] addr, input logic [127:0] wd, input bit hold);
    int tries = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    while (cyc < last_acc + 6 + RD_LAT) begin
      tries++;
      if (tries > 50) begin
        chk("accept_timeout", 1'b1, 1'b0);
        req_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    model_accept(cyc, wr, addr, wd);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    chk({tag, "_strobes"}, {bank_en, bank_rd, bank_wr}, 12'd0);
    chk({tag, "_bank_addr"}, bank_addr, 32'd0);
    chk({tag, "_bank_wdata"}, bank_wdata, 32'd0);
  endtask

  localparam logic [127:0] LINE_A = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

  initial begin
    #3 rst = 1'b1;
    #1 check_reset_outputs("reset");
    chk("reset_rsp_rdata", rsp_rdata, 128'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    send(1'b1, 32'h40, LINE_A, 1'b0);
    idle(10);
    send(1'b0, 32'h40, '0, 1'b0);
    idle(10);

    send(1'b0, 32'h40, '0, 1'b1);
    send(1'b0, 32'h80, '0, 1'b0);
    idle(10);

    err_sched[cyc + 3] = 4'b0100;
    send(1'b0, 32'h40, '0, 1'b0);
    idle(10);
    send(1'b0, 32'h43, '0, 1'b0);
    idle(10);

    send(1'b0, 32'h40, '0, 1'b0);
    idle(2);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    sb.delete();
    exp_iss.delete();
    last_acc = -100;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send(1'b0, 32'h40, '0, 1'b0);
    idle(10);

    for (int c = cyc; c < cyc + 3000; c++)
      if ($urandom_range(0, 29) == 0) err_sched[c] = 4'd1 << $urandom_range(0, 3);
    for (int t = 0; t < 150; t++) begin
      logic [127:0] wd;
      logic [31:0]  addr;
      int           gap;
      wd   = {$urandom, $urandom, $urandom, $urandom};
      addr = ((32'h100 + $urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      gap  = $urandom_range(0, 3);
      send(1'($urandom_range(0, 1)), addr, wd, gap == 0);
      idle(gap);
    end
    idle(15);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
